// File: rtl/match_dispatch_scheduler.sv
// Round-robin dispatcher for per-slot match events: latches dt at trigger time,
// keeps one pending entry per slot and drains them onto a single valid/ready stream.
module match_dispatch_scheduler #(
    parameter int NUM_SLOTS = 37,
    parameter int TW        = 16,
    parameter int SW        = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TW-1:0]           song_time,
    input  logic [NUM_SLOTS-1:0]    match_trigger,
    input  logic [NUM_SLOTS*TW-1:0] match_time,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SW-1:0]           out_slot,
    output logic [TW-1:0]           out_dt,
    output logic                    overflow,
    output logic                    busy
);

    logic [NUM_SLOTS-1:0] pending_q;
    logic [NUM_SLOTS-1:0] pending_d;
    logic [TW-1:0]        dt_q [NUM_SLOTS];
    logic [SW-1:0]        ptr_q;
    logic                 out_valid_q;
    logic [SW-1:0]        out_slot_q;
    logic [TW-1:0]        out_dt_q;
    logic                 overflow_q;
    logic                 busy_q;

    logic                 free;
    logic                 grant_found;
    logic [SW-1:0]        grant_idx;
    logic [NUM_SLOTS-1:0] grant_vec;
    logic [NUM_SLOTS-1:0] capture;
    logic [SW:0]          cand;

    assign free = !out_valid_q || out_ready;

    // Scan NUM_SLOTS candidates starting at ptr, wrapping at NUM_SLOTS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            cand = {1'b0, ptr_q} + (SW+1)'(k);
            if (cand >= (SW+1)'(NUM_SLOTS))
                cand = cand - (SW+1)'(NUM_SLOTS);
            if (!grant_found && pending_q[cand[SW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SW-1:0];
            end
        end
    end

    assign grant_vec = (free && grant_found) ? (NUM_SLOTS'(1) << grant_idx) : '0;
    // A slot being granted this edge may be retriggered without counting as a drop.
    assign capture   = match_trigger & (~pending_q | grant_vec);
    assign pending_d = (pending_q & ~grant_vec) | match_trigger;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)
                dt_q[i] <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_slot_q  <= '0;
            out_dt_q    <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (capture[i])
                    dt_q[i] <= song_time - match_time[i*TW +: TW];
            end
            overflow_q <= |(match_trigger & pending_q & ~grant_vec);
            busy_q     <= (|pending_q) || out_valid_q;
            if (free) begin
                if (grant_found) begin
                    out_valid_q <= 1'b1;
                    out_slot_q  <= grant_idx;
                    out_dt_q    <= dt_q[grant_idx];
                    ptr_q       <= (grant_idx == SW'(NUM_SLOTS-1)) ? '0 : grant_idx + SW'(1);
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_slot  = out_slot_q;
    assign out_dt    = out_dt_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_match_dispatch_scheduler.sv
// Directed bench for match_dispatch_scheduler: each scenario task drives inputs
// and checks outputs 1 time unit after the rising edge.
module tb_match_dispatch_scheduler;

    localparam int NUM_SLOTS = 37;
    localparam int TW        = 16;
    localparam int SW        = 6;

    logic                    clk;
    logic                    rst_n;
    logic [TW-1:0]           song_time;
    logic [NUM_SLOTS-1:0]    match_trigger;
    logic [NUM_SLOTS*TW-1:0] match_time;
    logic                    out_valid;
    logic                    out_ready;
    logic [SW-1:0]           out_slot;
    logic [TW-1:0]           out_dt;
    logic                    overflow;
    logic                    busy;

    int vectors;
    int errors;

    match_dispatch_scheduler #(.NUM_SLOTS(NUM_SLOTS), .TW(TW), .SW(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .song_time    (song_time),
        .match_trigger(match_trigger),
        .match_time   (match_time),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_slot     (out_slot),
        .out_dt       (out_dt),
        .overflow     (overflow),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mt(input int slot, input logic [TW-1:0] val);
        match_time[slot*TW +: TW] = val;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [SW-1:0] s,
                           input logic [TW-1:0] d);
        // drives nothing; only used to format identical three-field checks
        vectors++;
        if (out_valid !== v || (v && (out_slot !== s || out_dt !== d))) begin
            errors++;
            $display("FAIL %s: got valid=%b slot=%0d dt=%h, exp valid=%b slot=%0d dt=%h",
                     name, out_valid, out_slot, out_dt, v, s, d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        song_time = '0;
        match_trigger = '0;
        match_time = '0;
        out_ready = 1'b1;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_slot !== '0 || out_dt !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b slot=%0d dt=%h ovf=%b busy=%b, exp all 0",
                     out_valid, out_slot, out_dt, overflow, busy);
        end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        song_time = 16'd10;
        set_mt(0, 16'd7);
        match_trigger = 37'd1;
        step();
        match_trigger = '0;
        chk_out("single_latency", 1'b0, 6'd0, 16'd0);
        step();
        chk_out("single_event", 1'b1, 6'd0, 16'd3);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b exp 1", busy);
        end
        step();
        chk_out("single_done", 1'b0, 6'd0, 16'd0);
    endtask

    task automatic test_simultaneous();
        song_time = 16'd50;
        set_mt(3, 16'd40);
        set_mt(20, 16'd50);
        set_mt(36, 16'd60);
        match_trigger = '0;
        match_trigger[3] = 1'b1;
        match_trigger[20] = 1'b1;
        match_trigger[36] = 1'b1;
        step();
        match_trigger = '0;
        step();
        chk_out("simul_first", 1'b1, 6'd3, 16'd10);
        step();
        chk_out("simul_second", 1'b1, 6'd20, 16'd0);
        step();
        chk_out("simul_third", 1'b1, 6'd36, 16'hFFF6);
        step();
        chk_out("simul_drain", 1'b0, 6'd0, 16'd0);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_busy_lag: got %b exp 1", busy);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL simul_busy_drop: got %b exp 0", busy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        song_time = 16'd200;
        set_mt(0, 16'd190);
        set_mt(1, 16'd150);
        match_trigger = 37'b11;
        step();
        match_trigger = '0;
        step();
        chk_out("bp_grant0", 1'b1, 6'd0, 16'd10);
        for (int c = 0; c < 10; c++) begin
            step();
            chk_out("bp_hold", 1'b1, 6'd0, 16'd10);
        end
        out_ready = 1'b1;
        step();
        chk_out("bp_release1", 1'b1, 6'd1, 16'd50);
        song_time = 16'd300;
        set_mt(0, 16'd299);
        set_mt(2, 16'd290);
        match_trigger = 37'b101;
        step();
        match_trigger = '0;
        chk_out("bp_gap", 1'b0, 6'd0, 16'd0);
        step();
        chk_out("rr_slot2_first", 1'b1, 6'd2, 16'd10);
        step();
        chk_out("rr_slot0_second", 1'b1, 6'd0, 16'd1);
        step();
        chk_out("rr_drain", 1'b0, 6'd0, 16'd0);
    endtask

    task automatic test_sign();
        song_time = 16'd90;
        set_mt(5, 16'd100);
        match_trigger = '0;
        match_trigger[5] = 1'b1;
        step();
        match_trigger = '0;
        step();
        chk_out("sign_early", 1'b1, 6'd5, 16'hFFF6);
        song_time = 16'd3;
        set_mt(9, 16'hFFFE);
        match_trigger[9] = 1'b1;
        step();
        match_trigger = '0;
        step();
        chk_out("sign_wrap", 1'b1, 6'd9, 16'd5);
        step();
        chk_out("sign_drain", 1'b0, 6'd0, 16'd0);
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        song_time = 16'd104;
        set_mt(6, 16'd0);
        set_mt(7, 16'd100);
        match_trigger = '0;
        match_trigger[6] = 1'b1;
        step();
        match_trigger = '0;
        step();
        chk_out("ovf_hold6", 1'b1, 6'd6, 16'd104);
        match_trigger[7] = 1'b1;
        step();
        song_time = 16'd109;
        step();
        match_trigger = '0;
        vectors++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pulse: got %b exp 1", overflow);
        end
        step();
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_one_cycle: got %b exp 0", overflow);
        end
        out_ready = 1'b1;
        step();
        chk_out("ovf_first_dt_kept", 1'b1, 6'd7, 16'd4);
        out_ready = 1'b0;
        song_time = 16'd120;
        match_trigger[7] = 1'b1;
        step();
        match_trigger = '0;
        chk_out("ovf_held7", 1'b1, 6'd7, 16'd4);
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_requeue_no_pulse: got %b exp 0", overflow);
        end
        out_ready = 1'b1;
        step();
        chk_out("ovf_requeued", 1'b1, 6'd7, 16'd20);
        step();
        chk_out("ovf_drain", 1'b0, 6'd0, 16'd0);
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        song_time = 16'd500;
        match_trigger = '0;
        for (int s = 10; s <= 15; s++)
            match_trigger[s] = 1'b1;
        step();
        match_trigger = '0;
        step();
        chk_out("rst_pre", 1'b1, 6'd10, 16'd500);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_slot !== '0 || out_dt !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b slot=%0d dt=%h ovf=%b busy=%b, exp all 0",
                     out_valid, out_slot, out_dt, overflow, busy);
        end
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_stale: cycle %0d got valid=%b busy=%b, exp 0 0", c, out_valid, busy);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_sign();
        test_overflow();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
